// File: rtl/jtkcpu_bus_pkg.sv
// Shared types for the jtkcpu memory-bus front end: region codes, FSM states
// and the address-region decoder.
package jtkcpu_bus_pkg;

  localparam int IO_CNT_W = 4;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_ROM,
    REG_IO
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROM_REQ,
    ST_IO_WAIT,
    ST_IO_DONE
  } state_e;

  function automatic region_e decode_region(input logic [2:0] sel,
                                            input logic [2:0] ram_sel,
                                            input logic [2:0] io_sel);
    if (sel == ram_sel) return REG_RAM;
    if (sel == io_sel)  return REG_IO;
    return REG_ROM;
  endfunction

endpackage

// File: rtl/jtkcpu_bus_if.sv
// CPU-side bus of the jtkcpu front end: the core is the master, the bus
// decoder is the slave that answers with read data and dtack.
interface jtkcpu_bus_if;
  logic [23:0] addr;
  logic        we;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        dtack;

  modport master (output addr, we, cpu_dout, input cpu_din, dtack);
  modport slave  (input addr, we, cpu_dout, output cpu_din, dtack);
endinterface

// File: rtl/jtkcpu_bus_ram.sv
// Single-port work RAM, 2^AW x 8, synchronous write and registered read
// (read data is valid one clk after the address).
module jtkcpu_bus_ram #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    q
);

  logic [7:0] mem [2**AW];

  // NOTE: the array itself is never reset so it maps onto block RAM; only
  // the output register gets a reset value.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= mem[addr];
  end

endmodule

// File: rtl/jtkcpu_bus.sv
// Memory-bus front end for the jtkcpu core: decodes each access into work
// RAM, cached external ROM or wait-stated I/O and paces the core via dtack.
module jtkcpu_bus
  import jtkcpu_bus_pkg::*;
#(
  parameter int         RAM_AW  = 13,
  parameter logic [2:0] RAM_SEL = 3'b000,
  parameter logic [2:0] IO_SEL  = 3'b001,
  parameter int         IO_WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  jtkcpu_bus_if.slave   cpu,
  output logic [23:0]   rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [7:0]    rom_data,
  output logic          io_cs,
  output logic [12:0]   io_addr,
  input  logic [7:0]    io_din,
  output logic          io_we
);

  region_e             region;
  state_e              state;
  logic [7:0]          ram_q;
  logic                cache_valid;
  logic [23:0]         cache_tag;
  logic [7:0]          cache_data;
  logic                hit;
  logic [IO_CNT_W-1:0] io_cnt;
  logic [23:0]         io_key_addr;
  logic                io_key_we;
  logic                io_match;
  logic [7:0]          io_data;

  assign region   = decode_region(cpu.addr[15:13], RAM_SEL, IO_SEL);
  assign hit      = cache_valid & (cache_tag == cpu.addr) & ~cpu.we;
  assign io_match = (cpu.addr == io_key_addr) & (cpu.we == io_key_we);

  jtkcpu_bus_ram #(.AW(RAM_AW)) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (cpu.we & cen & (region == REG_RAM)),
    .addr (cpu.addr[RAM_AW-1:0]),
    .din  (cpu.cpu_dout),
    .q    (ram_q)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a latch behind.
  always_comb begin
    cpu.dtack = 1'b1;
    case (region)
      REG_ROM: cpu.dtack = cpu.we | hit;
      REG_IO:  cpu.dtack = (state == ST_IO_DONE) & io_match;
      default: cpu.dtack = 1'b1;
    endcase
    // Reset releases the core immediately even if an access was stalled.
    if (rst) cpu.dtack = 1'b1;
  end

  // Every source is already a register; the region only picks one.
  always_comb begin
    case (region)
      REG_RAM: cpu.cpu_din = ram_q;
      REG_IO:  cpu.cpu_din = io_data;
      default: cpu.cpu_din = cache_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rom_cs      <= 1'b0;
      rom_addr    <= '0;
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
      io_cs       <= 1'b0;
      io_we       <= 1'b0;
      io_addr     <= '0;
      io_cnt      <= '0;
      io_key_addr <= '0;
      io_key_we   <= 1'b0;
      io_data     <= '0;
    end else begin
      io_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (region == REG_ROM && !cpu.we && !hit) begin
            state    <= ST_ROM_REQ;
            rom_addr <= cpu.addr;
            rom_cs   <= 1'b1;
          end else if (region == REG_IO) begin
            state       <= ST_IO_WAIT;
            io_cnt      <= IO_CNT_W'(IO_WAIT);
            io_cs       <= 1'b1;
            io_addr     <= cpu.addr[12:0];
            io_key_addr <= cpu.addr;
            io_key_we   <= cpu.we;
          end
        end
        // A moved address does not abort: the fill uses the latched tag.
        ST_ROM_REQ: begin
          if (rom_ok) begin
            cache_valid <= 1'b1;
            cache_tag   <= rom_addr;
            cache_data  <= rom_data;
            rom_cs      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_IO_WAIT: begin
          if (io_cnt == '0) begin
            io_we   <= io_key_we;
            io_data <= io_din;
            state   <= ST_IO_DONE;
          end else if (cen) begin
            io_cnt <= io_cnt - 1'b1;
          end
        end
        ST_IO_DONE: begin
          if (!io_match) begin
            io_cs <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkcpu_bus.sv
// Bench for jtkcpu_bus: a CPU driver pushes each access's expected wait count
// and read data; a monitor pops and compares when the core would advance.
module tb_jtkcpu_bus;

  typedef struct {
    string      name;
    bit         is_read;
    logic [7:0] data;
    int         waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [23:0] rom_addr;
  logic        rom_cs;
  logic        rom_ok;
  logic [7:0]  rom_data;
  logic        io_cs;
  logic [12:0] io_addr;
  logic [7:0]  io_din;
  logic        io_we;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  bit   acc_active = 1'b0;
  bit   acc_done   = 1'b0;
  int   mon_waits  = 0;

  // ROM responder and bookkeeping
  bit          rom_en   = 1'b1;
  int          rom_lat  = 5;
  int          lat      = 0;
  logic [7:0]  rom_val  = 8'h00;
  int          rom_reqs = 0;
  logic [23:0] last_rom_addr = '0;
  logic        cs_prev  = 1'b0;

  int          io_we_cnt  = 0;
  logic [12:0] io_we_addr = '0;
  logic        io_we_cs   = 1'b0;

  jtkcpu_bus_if bus ();

  jtkcpu_bus #(.IO_WAIT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .cpu      (bus),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_ok   (rom_ok),
    .rom_data (rom_data),
    .io_cs    (io_cs),
    .io_addr  (io_addr),
    .io_din   (io_din),
    .io_we    (io_we)
  );

  always #5 clk = ~clk;

  initial begin
    cen = 1'b0;
    forever begin
      @(posedge clk);
      #1 cen = ~cen;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: the core advances on a clk where dtack and cen are high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (acc_active && !acc_done) begin
        if (!bus.dtack) begin
          mon_waits++;
        end else if (cen) begin
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got completion expected none");
          end else begin
            e = sb.pop_front();
            check({e.name, "_wait"}, mon_waits, e.waits);
            if (e.is_read) check({e.name, "_data"}, bus.cpu_din, e.data);
          end
          acc_done = 1'b1;
        end
      end
      if (io_we) begin
        io_we_cnt++;
        io_we_addr = io_addr;
        io_we_cs   = io_cs;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rom_cs && !cs_prev) begin
        rom_reqs++;
        last_rom_addr = rom_addr;
      end
      cs_prev = rom_cs;
      if (rom_en) begin
        if (rom_ok) begin
          rom_ok = 1'b0;
        end else if (rom_cs) begin
          lat++;
          if (lat == rom_lat) begin
            rom_ok   = 1'b1;
            rom_data = rom_val;
            lat      = 0;
          end
        end else begin
          lat = 0;
        end
      end
    end
  end

  // Start each access just after a cen tick, in a clk where cen is low.
  task automatic align();
    do begin
      @(posedge clk);
      #2;
    end while (cen !== 1'b0);
  endtask

  task automatic cpu_access(input string name, input logic [23:0] a, input logic w,
                            input logic [7:0] d, input int exp_w);
    exp_t e;
    align();
    bus.addr     = a;
    bus.we       = w;
    bus.cpu_dout = d;
    e.name = name; e.is_read = !w; e.data = d; e.waits = exp_w;
    sb.push_back(e);
    mon_waits  = 0;
    acc_done   = 1'b0;
    acc_active = 1'b1;
    for (int i = 0; i < 200 && !acc_done; i++) @(negedge clk);
    if (!acc_done) begin
      errors++;
      $display("FAIL %s_timeout: got no dtack expected completion", name);
      sb.delete();
    end
    acc_active = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.addr     = 24'h128000;
    bus.we       = 1'b0;
    bus.cpu_dout = 8'h00;
    rom_ok       = 1'b0;
    rom_data     = 8'h00;
    io_din       = 8'h9E;
    repeat (3) @(negedge clk);
    check("rst_dtack", bus.dtack, 1'b1);
    check("rst_rom_cs", rom_cs, 1'b0);
    check("rst_rom_addr", rom_addr, 24'h0);
    check("rst_io_cs", io_cs, 1'b0);
    check("rst_io_we", io_we, 1'b0);
    check("rst_cpu_din", bus.cpu_din, 8'h00);
    bus.addr = 24'h000000;
    @(negedge clk);
    rst = 1'b0;

    // Work RAM
    cpu_access("ram_wr",      24'h000123, 1'b1, 8'h5A, 0);
    cpu_access("ram_wr_top",  24'h001FFF, 1'b1, 8'hA5, 0);
    cpu_access("ram_rd",      24'h000123, 1'b0, 8'h5A, 0);
    cpu_access("ram_rd_top",  24'h001FFF, 1'b0, 8'hA5, 0);
    cpu_access("ram_rd_bank", 24'h7F0123, 1'b0, 8'h5A, 0);

    // ROM miss, hit, bank change, ignored write
    rom_lat = 5; rom_val = 8'hC3;
    cpu_access("rom_miss", 24'h128000, 1'b0, 8'hC3, 6);
    check("rom_miss_addr", last_rom_addr, 24'h128000);
    check("rom_miss_reqs", rom_reqs, 1);
    cpu_access("rom_hit", 24'h128000, 1'b0, 8'hC3, 0);
    check("rom_hit_reqs", rom_reqs, 1);
    rom_lat = 2; rom_val = 8'h3C;
    cpu_access("rom_bank", 24'h138000, 1'b0, 8'h3C, 3);
    check("rom_bank_addr", last_rom_addr, 24'h138000);
    check("rom_bank_reqs", rom_reqs, 2);
    cpu_access("rom_wr",   24'h138000, 1'b1, 8'h11, 0);
    cpu_access("rom_hit2", 24'h138000, 1'b0, 8'h3C, 0);
    check("rom_wr_reqs", rom_reqs, 2);

    // I/O write then read, two cen ticks of stall each
    cpu_access("io_wr", 24'h002004, 1'b1, 8'h77, 5);
    check("io_we_cnt", io_we_cnt, 1);
    check("io_we_addr", io_we_addr, 13'h0004);
    check("io_we_cs", io_we_cs, 1'b1);
    cpu_access("ram_rd2", 24'h000123, 1'b0, 8'h5A, 0);
    cpu_access("io_rd", 24'h002010, 1'b0, 8'h9E, 5);
    check("io_rd_we_cnt", io_we_cnt, 1);
    cpu_access("ram_rd3", 24'h001FFF, 1'b0, 8'hA5, 0);

    // Address moves to RAM while a ROM request is outstanding
    rom_lat = 6; rom_val = 8'h5C;
    align();
    bus.addr = 24'h148000;
    bus.we   = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    check("redir_cs", rom_cs, 1'b1);
    check("redir_addr", rom_addr, 24'h148000);
    cpu_access("redir_ram", 24'h000123, 1'b0, 8'h5A, 0);
    check("redir_hold", rom_cs, 1'b1);
    for (int i = 0; i < 50 && rom_cs; i++) @(negedge clk);
    check("redir_release", rom_cs, 1'b0);
    cpu_access("redir_hit", 24'h148000, 1'b0, 8'h5C, 0);
    check("redir_reqs", rom_reqs, 3);

    // Reset in the middle of a ROM request; a late rom_ok is ignored
    rom_lat = 100; lat = 0;
    align();
    bus.addr = 24'h158000;
    repeat (2) begin @(posedge clk); #2; end
    check("rstreq_cs_before", rom_cs, 1'b1);
    rst = 1'b1;
    #1;
    check("rstreq_cs", rom_cs, 1'b0);
    check("rstreq_dtack", bus.dtack, 1'b1);
    rom_en   = 1'b0;
    bus.addr = 24'h000000;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    rom_ok = 1'b1; rom_data = 8'hEE;
    @(posedge clk); #2;
    rom_ok = 1'b0;
    check("late_ok_cs", rom_cs, 1'b0);
    lat = 0; rom_lat = 3; rom_val = 8'h6D; rom_en = 1'b1;
    cpu_access("post_rst_miss", 24'h158000, 1'b0, 8'h6D, 4);
    check("post_rst_reqs", rom_reqs, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
